// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: opcode map, queue entry, decoded
// instruction record and the immediate-assembly helper.
package decode_queue_pkg;

    localparam int DQ_DEPTH_DEFAULT = 8;

    // RV32I base opcodes (inst[6:0]).
    typedef enum logic [6:0] {
        OPC_LOAD     = 7'h03,
        OPC_MISC_MEM = 7'h0F,
        OPC_OP_IMM   = 7'h13,
        OPC_AUIPC    = 7'h17,
        OPC_STORE    = 7'h23,
        OPC_OP       = 7'h33,
        OPC_LUI      = 7'h37,
        OPC_BRANCH   = 7'h63,
        OPC_JALR     = 7'h67,
        OPC_JAL      = 7'h6F,
        OPC_SYSTEM   = 7'h73
    } rv32i_opcode_t;

    // Immediate encoding formats.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_t;

    // One queued fetch packet.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    // Fields and flags produced by the decoder for the head entry.
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        writes_rd;
        logic        illegal;
    } decoded_inst_t;

    // Assemble the sign-extended immediate for a given format.
    function automatic logic [31:0] build_imm(input logic [31:0] inst, input imm_fmt_t fmt);
        logic [31:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'h000};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_queue_decoder.sv
// Purely combinational RV32I field decode of one instruction word.
module rv32i_decoder
    import decode_queue_pkg::*;
(
    input  logic [31:0]   inst,
    output decoded_inst_t dec
);

    imm_fmt_t fmt_s;
    logic     uses_rs1_s;
    logic     uses_rs2_s;
    logic     wr_s;
    logic     illegal_s;

    // Classify the opcode into an immediate format and operand-usage flags.
    always_comb begin
        fmt_s      = FMT_R;
        uses_rs1_s = 1'b0;
        uses_rs2_s = 1'b0;
        wr_s       = 1'b0;
        illegal_s  = 1'b0;
        case (inst[6:0])
            OPC_OP:       begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; wr_s = 1'b1; end
            OPC_OP_IMM:   begin fmt_s = FMT_I; uses_rs1_s = 1'b1; wr_s = 1'b1; end
            OPC_LOAD:     begin fmt_s = FMT_I; uses_rs1_s = 1'b1; wr_s = 1'b1; end
            OPC_STORE:    begin fmt_s = FMT_S; uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; end
            OPC_BRANCH:   begin fmt_s = FMT_B; uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; end
            OPC_JALR:     begin fmt_s = FMT_I; uses_rs1_s = 1'b1; wr_s = 1'b1; end
            OPC_JAL:      begin fmt_s = FMT_J; wr_s = 1'b1; end
            OPC_LUI:      begin fmt_s = FMT_U; wr_s = 1'b1; end
            OPC_AUIPC:    begin fmt_s = FMT_U; wr_s = 1'b1; end
            // FENCE and ECALL/EBREAK are legal base instructions but touch
            // no integer registers from the scheduler's point of view.
            OPC_MISC_MEM: begin fmt_s = FMT_I; end
            OPC_SYSTEM:   begin fmt_s = FMT_I; end
            default:      begin illegal_s = 1'b1; end
        endcase
    end

    // Pack the raw fields and flags; a write to x0 is not a real write.
    always_comb begin
        dec.opcode    = inst[6:0];
        dec.funct3    = inst[14:12];
        dec.funct7    = inst[31:25];
        dec.rd        = inst[11:7];
        dec.rs1       = inst[19:15];
        dec.rs2       = inst[24:20];
        dec.imm       = build_imm(inst, fmt_s);
        dec.uses_rs1  = uses_rs1_s;
        dec.uses_rs2  = uses_rs2_s;
        dec.writes_rd = wr_s && (inst[11:7] != 5'd0);
        dec.illegal   = illegal_s;
    end

endmodule

// File: rtl/decode_queue.sv
// Instruction queue between fetch and dispatch: circular FIFO of fetch
// packets with combinational decode of the head entry.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = DQ_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        valid_inst,
    input  logic [63:0] inst_in,
    output logic        iq_full,
    input  logic        rob_full,
    input  logic        rs_full,
    output logic        dispatch_valid,
    output logic [31:0] dispatch_pc,
    output logic [31:0] dispatch_inst,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        writes_rd,
    output logic        illegal
);

    localparam int            PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW         = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    iq_entry_t     mem_q [DEPTH];

    logic          push_s;
    logic          pop_s;
    iq_entry_t     head_entry_s;
    decoded_inst_t dec_s;

    // Handshake terms; fullness comes from the registered count only, so a
    // pop at full cannot make room for a push in the same cycle.
    always_comb begin
        iq_full        = (count_q == FULL_COUNT);
        dispatch_valid = (count_q != {CW{1'b0}}) && !flush;
        push_s         = valid_inst && !iq_full && !flush;
        pop_s          = dispatch_valid && !rob_full && !rs_full;
    end

    // Next pointer/count values; flush empties the queue outright.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (push_s) begin
                tail_d = tail_q + PW'(1);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers; reset overrides everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; left unreset because the pointers define what is live.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_q[tail_q] <= inst_in;
        end
    end

    assign head_entry_s = mem_q[head_q];

    rv32i_decoder u_decoder (
        .inst (head_entry_s.inst),
        .dec  (dec_s)
    );

    assign dispatch_pc   = head_entry_s.pc;
    assign dispatch_inst = head_entry_s.inst;
    assign opcode        = dec_s.opcode;
    assign funct3        = dec_s.funct3;
    assign funct7        = dec_s.funct7;
    assign rd            = dec_s.rd;
    assign rs1           = dec_s.rs1;
    assign rs2           = dec_s.rs2;
    assign imm           = dec_s.imm;
    assign uses_rs1      = dec_s.uses_rs1;
    assign uses_rs2      = dec_s.uses_rs2;
    assign writes_rd     = dec_s.writes_rd;
    assign illegal       = dec_s.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: in-order delivery, backpressure, flush,
// reset and decode of representative RV32I encodings.
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid_inst;
    logic [63:0] inst_in;
    logic        iq_full;
    logic        rob_full;
    logic        rs_full;
    logic        dispatch_valid;
    logic [31:0] dispatch_pc;
    logic [31:0] dispatch_inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .valid_inst     (valid_inst),
        .inst_in        (inst_in),
        .iq_full        (iq_full),
        .rob_full       (rob_full),
        .rs_full        (rs_full),
        .dispatch_valid (dispatch_valid),
        .dispatch_pc    (dispatch_pc),
        .dispatch_inst  (dispatch_inst),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .imm            (imm),
        .uses_rs1       (uses_rs1),
        .uses_rs2       (uses_rs2),
        .writes_rd      (writes_rd),
        .illegal        (illegal)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ADDI x1, x0, k
    function automatic logic [31:0] addi_word(input int k);
        return {12'(k), 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    task automatic push_n(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            valid_inst = 1'b1;
            inst_in    = {base + 32'(4 * i), addi_word(i)};
            tick();
        end
        valid_inst = 1'b0;
    endtask

    // Feed entries pre..n_total-1 (holding while full) and check that all
    // n_total entries starting at base come out in order exactly once.
    task automatic run_stream(input logic [31:0] base, input int n_total, input int pre,
                              input bit toggle_rs);
        int next_push;
        int next_pop;
        int cyc;
        next_push = pre;
        next_pop  = 0;
        cyc       = 0;
        rob_full  = 1'b0;
        while (next_pop < n_total && cyc < 200) begin
            valid_inst = (next_push < n_total);
            inst_in    = {base + 32'(4 * next_push), addi_word(next_push)};
            rs_full    = toggle_rs ? cyc[0] : 1'b0;
            #1;
            if (dispatch_valid) begin
                check_eq("stream_pc", dispatch_pc, base + 32'(4 * next_pop));
                check_eq("stream_imm", imm, 32'(next_pop));
                if (!rs_full) next_pop++;
            end
            if (valid_inst && !iq_full) next_push++;
            tick();
            cyc++;
        end
        valid_inst = 1'b0;
        rs_full    = 1'b0;
        check_eq("stream_count", next_pop, n_total);
        #1;
        check_eq("stream_drained", dispatch_valid, 1'b0);
    endtask

    task automatic push_head(input logic [31:0] word);
        valid_inst = 1'b1;
        inst_in    = {32'h4000_0000, word};
        tick();
        valid_inst = 1'b0;
        #1;
        check_eq("dec_valid", dispatch_valid, 1'b1);
        check_eq("dec_inst", dispatch_inst, word);
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        valid_inst = 1'b0;
        inst_in    = 64'h0;
        rob_full   = 1'b0;
        rs_full    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("reset_dv", dispatch_valid, 1'b0);
        check_eq("reset_full", iq_full, 1'b0);

        // Three back-to-back ADDIs with no backpressure.
        valid_inst = 1'b1;
        inst_in    = {32'h6000_0000, 32'h0050_0093};
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) begin
                inst_in = {32'h6000_0000 + 32'(4 * (i + 1)), 32'h0050_0093};
            end else begin
                valid_inst = 1'b0;
            end
            #1;
            check_eq("t1_dv", dispatch_valid, 1'b1);
            check_eq("t1_pc", dispatch_pc, 32'h6000_0000 + 32'(4 * i));
            check_eq("t1_imm", imm, 32'd5);
            check_eq("t1_wr", writes_rd, 1'b1);
            check_eq("t1_rd", rd, 5'd1);
            check_eq("t1_opc", opcode, 7'h13);
        end
        tick();
        #1;
        check_eq("t1_empty", dispatch_valid, 1'b0);

        // Fill to full under ROB backpressure, hold a ninth, then drain.
        rob_full = 1'b1;
        push_n(32'h0000_1000, 8);
        #1;
        check_eq("t2_full", iq_full, 1'b1);
        check_eq("t2_head_pc", dispatch_pc, 32'h0000_1000);
        valid_inst = 1'b1;
        inst_in    = {32'h0000_1020, addi_word(8)};
        tick();
        tick();
        #1;
        check_eq("t2_still_full", iq_full, 1'b1);
        check_eq("t2_head_stable", dispatch_pc, 32'h0000_1000);
        check_eq("t2_head_inst", dispatch_inst, addi_word(0));
        run_stream(32'h0000_1000, 9, 8, 1'b0);

        // Flush at count 5 with a concurrent fetch.
        rob_full = 1'b1;
        push_n(32'h0000_2000, 5);
        valid_inst = 1'b1;
        inst_in    = {32'h0000_2FF0, addi_word(99)};
        flush      = 1'b1;
        #1;
        check_eq("t3_dv_in_flush", dispatch_valid, 1'b0);
        tick();
        flush      = 1'b0;
        valid_inst = 1'b0;
        #1;
        check_eq("t3_dv_after", dispatch_valid, 1'b0);
        check_eq("t3_full_after", iq_full, 1'b0);
        rob_full = 1'b0;
        tick();
        tick();
        #1;
        check_eq("t3_no_stale", dispatch_valid, 1'b0);
        run_stream(32'h0000_3000, 3, 0, 1'b0);

        // Decode of representative encodings.
        push_head(32'hFE20_8EE3);                   // beq x1, x2, -4
        check_eq("beq_imm", imm, 32'hFFFF_FFFC);
        check_eq("beq_rs1", uses_rs1, 1'b1);
        check_eq("beq_rs2", uses_rs2, 1'b1);
        check_eq("beq_wr", writes_rd, 1'b0);
        check_eq("beq_ill", illegal, 1'b0);
        check_eq("beq_regs", {rs1, rs2}, {5'd1, 5'd2});
        tick();
        push_head(32'h0000_007F);                   // unknown opcode
        check_eq("ill_flag", illegal, 1'b1);
        check_eq("ill_flags", {uses_rs1, uses_rs2, writes_rd}, 3'b000);
        tick();
        push_head(32'h1234_52B7);                   // lui x5, 0x12345
        check_eq("lui_imm", imm, 32'h1234_5000);
        check_eq("lui_flags", {uses_rs1, uses_rs2, writes_rd}, 3'b001);
        check_eq("lui_rd", rd, 5'd5);
        tick();
        push_head(32'hFE20_AC23);                   // sw x2, -8(x1)
        check_eq("sw_imm", imm, 32'hFFFF_FFF8);
        check_eq("sw_f3", funct3, 3'd2);
        check_eq("sw_flags", {uses_rs1, uses_rs2, writes_rd}, 3'b110);
        tick();
        push_head(32'h0080_00EF);                   // jal x1, 8
        check_eq("jal_imm", imm, 32'd8);
        check_eq("jal_flags", {uses_rs1, uses_rs2, writes_rd}, 3'b001);
        tick();
        push_head(32'h4020_81B3);                   // sub x3, x1, x2
        check_eq("sub_f7", funct7, 7'h20);
        check_eq("sub_imm", imm, 32'h0);
        check_eq("sub_flags", {uses_rs1, uses_rs2, writes_rd}, 3'b111);
        tick();
        push_head(32'h0020_8033);                   // add x0, x1, x2
        check_eq("add_x0_wr", writes_rd, 1'b0);
        check_eq("add_x0_rs2", uses_rs2, 1'b1);
        tick();

        // Twelve entries with RS backpressure toggling; pointers wrap.
        run_stream(32'h0000_5000, 12, 0, 1'b1);

        // Reset mid-stream at count 4 with a concurrent fetch.
        rob_full = 1'b1;
        push_n(32'h0000_7000, 4);
        rst        = 1'b1;
        valid_inst = 1'b1;
        inst_in    = {32'h0000_7FF0, addi_word(77)};
        tick();
        rst        = 1'b0;
        valid_inst = 1'b0;
        #1;
        check_eq("t6_dv", dispatch_valid, 1'b0);
        check_eq("t6_full", iq_full, 1'b0);
        rob_full = 1'b0;
        tick();
        #1;
        check_eq("t6_no_stale", dispatch_valid, 1'b0);
        run_stream(32'h0000_8000, 2, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of instruction-queue entries; power of two, at least 2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 flush  input  1  branch mispredict; discards all queued instructions.
REQ-005 valid_inst  input  1  fetch presents an instruction this cycle.
REQ-006 inst_in  input  64  fetch payload; [63:32] pc, [31:0] instruction word.
REQ-007 iq_full  output  1  queue cannot accept; fetch holds valid_inst/inst_in stable.
REQ-008 rob_full  input  1  ROB backpressure; blocks dispatch.
REQ-009 rs_full  input  1  reservation-station backpressure; blocks dispatch.
REQ-010 dispatch_valid  output  1  decoded head instruction presented downstream.
REQ-011 dispatch_pc  output  32  pc of head entry.
REQ-012 dispatch_inst  output  32  raw instruction word of head entry.
REQ-013 opcode  output  7;  funct3  output  3;  funct7  output  7  decoded fields of head entry.
REQ-014 rd, rs1, rs2  output  5 each  register specifiers of head entry.
REQ-015 imm  output  32  sign-extended immediate of head entry per format.
REQ-016 uses_rs1, uses_rs2, writes_rd  output  1 each  operand-usage flags.
REQ-017 illegal  output  1  head opcode not in RV32I base set.

Function
REQ-018 Queue SHALL be circular FIFO: head pointer, tail pointer, count of width clog2(DEPTH)+1; pointers wrap DEPTH-1 -> 0.
REQ-019 iq_full SHALL equal (count == DEPTH), combinational from registered count only.
REQ-020 Push SHALL occur at edge when valid_inst && !iq_full && !flush; entry written at tail, tail increments.
REQ-021 valid_inst while iq_full SHALL be ignored without state change; no entry lost since fetch holds.
REQ-022 dispatch_valid SHALL equal (count != 0) && !flush.
REQ-023 Pop SHALL occur at edge when dispatch_valid && !rob_full && !rs_full; head increments.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; pop at full frees no slot until next cycle (push blocked that cycle).
REQ-025 Latency: instruction pushed at edge N SHALL appear on dispatch outputs in cycle N+1 if queue was empty.
REQ-026 Dispatch outputs SHALL be combinational decode of head entry; stable while blocked by rob_full/rs_full.
REQ-027 Flush SHALL at next edge zero count, head, tail; same-cycle push and pop suppressed.
REQ-028 imm: I-type [31:20]; S-type {[31:25],[11:7]}; B-type {[31],[7],[30:25],[11:8],0}; U-type {[31:12],12'b0}; J-type {[31],[19:12],[20],[30:21],0}; all sign-extended from bit 31; R-type 0.
REQ-029 uses_rs1 SHALL be 1 for OP, OP-IMM, LOAD, STORE, BRANCH, JALR; uses_rs2 for OP, STORE, BRANCH.
REQ-030 writes_rd SHALL be 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and 0 when rd == 0.
REQ-031 illegal SHALL be 1 for any other opcode; uses_*/writes_rd then 0; entry still dispatches.
REQ-032 Output values while dispatch_valid is 0 SHALL be don't-care; bench checks only when valid.

Reset
REQ-033 rst at edge SHALL zero count, head, tail; iq_full = 0 and dispatch_valid = 0 the following cycle.
REQ-034 rst SHALL dominate flush, push, pop in same cycle; storage array not reset.
REQ-035 rst mid-stream SHALL discard all entries; no pre-reset entry dispatched afterward.

Structure
REQ-036 Shared package SHALL hold opcode enum (rv32i_opcode_t), iq_entry_t struct {pc, inst}, decoded-instruction struct, and DEPTH default constant.
REQ-037 Combinational decode SHALL be sub-module rv32i_decoder (inst in, decoded struct out); queue storage and control stay in decode_queue.

Verification
REQ-038 Push 3 instructions (pc 0x60000000, +4, +8; ADDI x1,x0,5) with no backpressure -> each dispatches in cycle after push, in order, imm = 5, writes_rd = 1.
REQ-039 Hold rob_full = 1, push 8 -> iq_full = 1 after 8th push; 9th held; release -> 9 dispatches in order, none lost or duplicated.
REQ-040 Queue at count 5, assert flush with valid_inst = 1 -> next cycle count 0, dispatch_valid = 0, flushed-cycle instruction never dispatched.
REQ-041 Decode: BEQ offset -4 -> imm = 0xFFFFFFFC, uses_rs1/rs2 = 1, writes_rd = 0; opcode 0x7F -> illegal = 1.
REQ-042 Push 12 with rs_full toggling every cycle -> pointers wrap, 12 dispatched in order.
REQ-043 rst asserted at count 4 -> next cycle dispatch_valid = 0, iq_full = 0; subsequent push dispatches correctly.
